// File: rtl/zuc_eea3_arb_pkg.sv
// Shared definitions for the zuc_eea3 message arbiter: control-word layout,
// FSM encoding and the channel-index width helper.
package zuc_eea3_arb_pkg;

  localparam int ZUC_CTL_PARAM_W = 166;
  localparam int ZUC_CK_LSB      = 0;
  localparam int ZUC_CK_W        = 128;
  localparam int ZUC_DIR_LSB     = 128;
  localparam int ZUC_BEARER_LSB  = 129;
  localparam int ZUC_BEARER_W    = 5;
  localparam int ZUC_COUNT_LSB   = 134;
  localparam int ZUC_COUNT_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CTL  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zuc_eea3_arb_if.sv
// Requester, core-side and tagged-output streams of the zuc_eea3 arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface zuc_eea3_arb_if
  import zuc_eea3_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int BW  = 8
) ();
  localparam int KW = 32 / BW;
  localparam int CW = chan_w(NCH);

  logic [NCH-1:0]                 s_ctl_valid;
  logic [NCH-1:0]                 s_ctl_ready;
  logic [ZUC_CTL_PARAM_W*NCH-1:0] s_ctl_param;
  logic [NCH-1:0]                 s_valid;
  logic [NCH-1:0]                 s_ready;
  logic [NCH-1:0]                 s_last;
  logic [32*NCH-1:0]              s_data;
  logic [KW*NCH-1:0]              s_keep;

  logic                       c_ctl_valid;
  logic                       c_ctl_ready;
  logic [ZUC_CTL_PARAM_W-1:0] c_ctl_param;
  logic                       c_valid;
  logic                       c_ready;
  logic                       c_last;
  logic [31:0]                c_data;
  logic [KW-1:0]              c_keep;

  logic          c_m_valid;
  logic          c_m_ready;
  logic          c_m_last;
  logic [31:0]   c_m_data;
  logic [KW-1:0] c_m_keep;

  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [31:0]   m_data;
  logic [KW-1:0] m_keep;
  logic [CW-1:0] m_chan;

  modport master (
    input  s_ctl_valid, s_ctl_param, s_valid, s_last, s_data, s_keep,
    output s_ctl_ready, s_ready,
    output c_ctl_valid, c_ctl_param, c_valid, c_last, c_data, c_keep,
    input  c_ctl_ready, c_ready,
    input  c_m_valid, c_m_last, c_m_data, c_m_keep,
    output c_m_ready,
    output m_valid, m_last, m_data, m_keep, m_chan,
    input  m_ready
  );

  modport slave (
    output s_ctl_valid, s_ctl_param, s_valid, s_last, s_data, s_keep,
    input  s_ctl_ready, s_ready,
    input  c_ctl_valid, c_ctl_param, c_valid, c_last, c_data, c_keep,
    output c_ctl_ready, c_ready,
    output c_m_valid, c_m_last, c_m_data, c_m_keep,
    input  c_m_ready,
    input  m_valid, m_last, m_data, m_keep, m_chan,
    output m_ready
  );

endinterface

// File: rtl/zuc_eea3_arb_chk.sv
// Protocol checker: the core must never emit output while no message id is queued.
module zuc_eea3_arb_chk (
  input logic clk,
  input logic rst,
  input logic i_c_m_valid,
  input logic i_fifo_empty
);

  a_no_output_without_id: assert property (
    @(posedge clk) disable iff (rst) !(i_c_m_valid && i_fifo_empty)
  );

endmodule

// File: rtl/zuc_id_fifo.sv
// Small synchronous FIFO holding the channel id of every message in flight
// inside the core, oldest at the head.
module zuc_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/zuc_eea3_arb.sv
// Message-granular round-robin arbiter sharing one zuc_eea3 core among nch
// requesters and tagging the core's in-order output with the source channel.
module zuc_eea3_arb
  import zuc_eea3_arb_pkg::*;
#(
  parameter int nch        = 4,
  parameter int bw         = 8,
  parameter int fifo_depth = 4
) (
  input logic             clk,
  input logic             rst,
  zuc_eea3_arb_if.master  bus
);
  localparam int KW = 32 / bw;
  localparam int CW = chan_w(nch);

  arb_state_e    r_state;
  arb_state_e    w_next;
  logic [CW-1:0] r_grant;
  logic [CW-1:0] r_rr;
  logic [CW-1:0] w_pick;
  logic [CW-1:0] w_fifo_head;
  logic          w_found;
  logic          w_full;
  logic          w_empty;
  logic          w_ctl_hs;
  logic          w_data_hs;
  logic          w_pop;

  // first requesting channel at or after the round-robin pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < nch; k++) begin
      if (!w_found && bus.s_ctl_valid[(int'(r_rr) + k) % nch]) begin
        w_found = 1'b1;
        w_pick  = CW'((int'(r_rr) + k) % nch);
      end
    end
  end

  assign w_ctl_hs  = (r_state == ST_CTL) && bus.s_ctl_valid[r_grant] && bus.c_ctl_ready;
  assign w_data_hs = (r_state == ST_DATA) && bus.s_valid[r_grant] && bus.c_ready;
  assign w_pop     = bus.c_m_valid && bus.c_m_ready && bus.c_m_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && (w_next == ST_CTL)) r_grant <= w_pick;
      if (w_ctl_hs) r_rr <= (r_grant == CW'(nch - 1)) ? '0 : r_grant + CW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_found && !w_full) w_next = ST_CTL;
               else                    w_next = ST_IDLE;
      ST_CTL:  if (w_ctl_hs)           w_next = ST_DATA;
               else                    w_next = ST_CTL;
      ST_DATA: if (w_data_hs && bus.s_last[r_grant]) w_next = ST_IDLE;
               else                                  w_next = ST_DATA;
      default: w_next = ST_IDLE;
    endcase
  end

  // handshakes are forced idle while reset is held, whatever the state register says
  always_comb begin
    bus.s_ctl_ready = '0;
    bus.s_ready     = '0;
    bus.c_ctl_valid = 1'b0;
    bus.c_ctl_param = '0;
    bus.c_valid     = 1'b0;
    bus.c_last      = 1'b0;
    bus.c_data      = '0;
    bus.c_keep      = '0;
    case (rst ? ST_IDLE : r_state)
      ST_CTL: begin
        bus.c_ctl_valid          = bus.s_ctl_valid[r_grant];
        bus.c_ctl_param          = bus.s_ctl_param[int'(r_grant)*ZUC_CTL_PARAM_W +: ZUC_CTL_PARAM_W];
        bus.s_ctl_ready[r_grant] = bus.c_ctl_ready;
      end
      ST_DATA: begin
        bus.c_valid          = bus.s_valid[r_grant];
        bus.c_last           = bus.s_last[r_grant];
        bus.c_data           = bus.s_data[int'(r_grant)*32 +: 32];
        bus.c_keep           = bus.s_keep[int'(r_grant)*KW +: KW];
        bus.s_ready[r_grant] = bus.c_ready;
      end
      default: begin
        bus.c_valid = 1'b0;
      end
    endcase
  end

  assign bus.m_valid   = !rst && bus.c_m_valid && !w_empty;
  assign bus.c_m_ready = !rst && bus.m_ready && !w_empty;
  assign bus.m_last    = bus.c_m_last;
  assign bus.m_data    = bus.c_m_data;
  assign bus.m_keep    = bus.c_m_keep;
  assign bus.m_chan    = w_fifo_head;

  zuc_id_fifo #(
    .W     (CW),
    .DEPTH (fifo_depth)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ctl_hs),
    .i_data  (r_grant),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  zuc_eea3_arb_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .i_c_m_valid  (bus.c_m_valid),
    .i_fifo_empty (w_empty)
  );

endmodule

// File: doc/zuc_eea3_arb.md
Name: zuc_eea3_arb

Overview:
Message-granular round-robin arbiter that shares one zuc_eea3 instance among nch requesters. Each requester presents ctl + data streams; the arbiter grants one message (ctl beat through the s_last data beat), steers it into the core, and tags the core's in-order output stream with the originating channel via an internal id FIFO.

Parameters:
nch, 4, number of requester channels (2..16); cw = max(1, clog2(nch)) derived, kw = 32/bw derived
bw, 8, keep granularity in bits (must match the zuc_eea3 instance)
fifo_depth, 4, outstanding-message id FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_ctl_valid  in  nch  per-channel ctl valid
s_ctl_ready  out  nch  per-channel ctl ready
s_ctl_param  in  166*nch  per-channel {count[31:0], bearer[4:0], direction, ck[127:0]}, channel i at [166*i+:166]
s_valid  in  nch  per-channel data valid
s_ready  out  nch  per-channel data ready
s_last  in  nch  per-channel last beat of message
s_data  in  32*nch  per-channel data word
s_keep  in  kw*nch  per-channel byte-lane keep
c_ctl_valid  out  1  to core s_ctl_valid
c_ctl_ready  in  1  from core s_ctl_ready
c_ctl_param  out  166  to core {s_ctl_count, s_ctl_bearer, s_ctl_direction, s_ctl_ck}
c_valid  out  1  to core s_valid
c_ready  in  1  from core s_ready
c_last  out  1  to core s_last
c_data  out  32  to core s_data
c_keep  out  kw  to core s_keep
c_m_valid  in  1  core m_valid
c_m_ready  out  1  core m_ready
c_m_last  in  1  core m_last
c_m_data  in  32  core m_data
c_m_keep  in  kw  core m_keep
m_valid  out  1  tagged output valid
m_ready  in  1  tagged output ready
m_last  out  1  last beat of message
m_data  out  32  ciphertext/plaintext word
m_keep  out  kw  byte-lane keep
m_chan  out  cw  originating channel of current output message

Behaviour:
- Reset: FSM=IDLE, rr pointer=0, id FIFO empty. All valid/ready outputs 0 during and immediately after reset. A reset mid-message drops the message: no partial state is retained, and the core must be reset alongside.
- FSM IDLE: when any s_ctl_valid is set and the FIFO is not full, pick the first requesting channel at or after rr (wrapping), register grant g, and go to CTL. With no request, or with the FIFO full, stay in IDLE; all s_ctl_ready and s_ready are 0.
- CTL: c_ctl_valid=s_ctl_valid[g], c_ctl_param=slice g, s_ctl_ready[g]=c_ctl_ready. On the handshake, push g into the FIFO, set rr=g+1 (mod nch), and go to DATA. Grant-to-c_ctl_valid latency is 1 cycle after the IDLE decision.
- DATA: c_valid/c_last/c_data/c_keep are a combinational mux of channel g; s_ready[g]=c_ready; s_ready is 0 for all other channels. On a handshake with s_last[g]=1, go to IDLE. Any message needs at least 2 cycles of arbitration overhead.
- Output: m_valid=c_m_valid && fifo_nonempty; c_m_ready=m_ready && fifo_nonempty; m_chan=FIFO head. Pop on an output handshake with c_m_last=1. A same-cycle push and pop is legal and leaves the count unchanged.
- m_data, m_keep and m_last pass through combinationally; the arbiter adds no output latency.
- The arbiter never alters data order. Messages for different channels may be in flight in the core at once, bounded by fifo_depth.
- Pop from an empty FIFO cannot occur by construction; an assertion flags c_m_valid with the FIFO empty.

Decomposition:
- Shared package: ZUC_CTL_PARAM_W=166 and field offsets for count/bearer/direction/ck.
- One sub-module: zuc_id_fifo (synchronous, width cw, depth fifo_depth, full/empty flags).

Test Plan:
- Single channel 2, one 3-beat message (keep 4'hF, 4'hF, 4'h3) -> core sees 1 ctl then 3 data beats; output has 3 beats, m_chan=2, and m_last only on beat 3.
- All 4 channels request at once from reset -> grants in order 0,1,2,3; m_chan sequence 0,1,2,3; rr returns to 0.
- Channel 1 requests continuously while channel 3 requests once -> order is 1,3,1; no starvation.
- m_ready held low with fifo_depth=4 and 6 queued 1-beat messages -> exactly 4 grants, then the FSM stalls in IDLE; releasing m_ready drains all 6 with correct m_chan.
- rst asserted for 1 cycle mid-DATA -> all readies/valids 0 next cycle, FIFO empty, next request granted from channel 0 search.
- 3GPP EEA3 test set 1 through channel 0 -> output matches the published ciphertext.
